decode_stage: RTL and testbench

Registered, handshaked instruction-decode stage between fetch and execute. Generalises the combinational decoder: parametrised for RV32/RV64, detects illegal instructions, classifies system instructions, extracts register fields and suppresses x0 writeback. A 2-entry skid buffer gives full throughput with a registered in_ready_o.

---
 rtl/decode_stage.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Registered, handshaked RV32/RV64 instruction-decode stage with a 2-entry skid buffer.
// Decode is combinational on instr_i; the bundle is captured into an output or skid register.

package decode_pkg;
  typedef enum logic [1:0] {Add = 2'd0, Branch = 2'd1, Op = 2'd2, Op32 = 2'd3} aluop_e;
  typedef enum logic [1:0] {JmpNone = 2'd0, Jal = 2'd1, Jalr = 2'd2} jump_e;
  typedef enum logic [1:0] {MemNone = 2'd0, MemLoad = 2'd1, MemStore = 2'd2} mem_type_e;
endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned Xlen    = 64,  // 32 or 64 only
  parameter int unsigned Ilen    = 32,
  parameter int unsigned PcWidth = Xlen
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [Ilen-1:0]    instr_i,
  input  logic [PcWidth-1:0] pc_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [PcWidth-1:0] pc_o,
  output logic [4:0]         rd_o,
  output logic [4:0]         rs1_o,
  output logic [4:0]         rs2_o,
  output logic [2:0]         funct3_o,
  output logic [6:0]         funct7_o,
  output logic [Xlen-1:0]    imm_o,
  output aluop_e             aluop_o,
  output logic               alu_use_imm_o,
  output logic               reg_wb_o,
  output logic               reg_lui_o,
  output logic               is_auipc_o,
  output logic               branch_o,
  output logic               mem_to_reg_o,
  output logic               is_csr_o,
  output jump_e              jump_o,
  output mem_type_e          mem_type_o,
  output logic               is_ecall_o,
  output logic               is_ebreak_o,
  output logic               is_mret_o,
  output logic               illegal_o
);

  localparam logic [6:0] OpcLoad    = 7'b0000011;
  localparam logic [6:0] OpcMiscMem = 7'b0001111;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;
  localparam logic [6:0] OpcOpImm32 = 7'b0011011;
  localparam logic [6:0] OpcStore   = 7'b0100011;
  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcOp32    = 7'b0111011;
  localparam logic [6:0] OpcBranch  = 7'b1100011;
  localparam logic [6:0] OpcJalr    = 7'b1100111;
  localparam logic [6:0] OpcJal     = 7'b1101111;
  localparam logic [6:0] OpcSystem  = 7'b1110011;

  typedef struct packed {
    logic [PcWidth-1:0] pc;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [Xlen-1:0]    imm;
    aluop_e             aluop;
    logic               alu_use_imm;
    logic               reg_wb;
    logic               reg_lui;
    logic               is_auipc;
    logic               branch;
    logic               mem_to_reg;
    logic               is_csr;
    jump_e              jump;
    mem_type_e          mem_type;
    logic               is_ecall;
    logic               is_ebreak;
    logic               is_mret;
    logic               illegal;
  } bundle_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  logic        illegal;
  bundle_t     dec;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21],
                   1'b0};

  always_comb begin
    dec     = '0;
    imm32   = '0;
    illegal = 1'b0;
    case (opcode)
      OpcOp: begin
        dec.reg_wb = 1'b1;
        dec.aluop  = Op;
      end
      OpcOpImm: begin
        dec.reg_wb      = 1'b1;
        dec.alu_use_imm = 1'b1;
        dec.aluop       = Op;
        imm32           = imm_i;
      end
      OpcOp32: begin
        illegal    = (Xlen == 32);
        dec.reg_wb = 1'b1;
        dec.aluop  = Op32;
      end
      OpcOpImm32: begin
        illegal         = (Xlen == 32);
        dec.reg_wb      = 1'b1;
        dec.alu_use_imm = 1'b1;
        dec.aluop       = Op32;
        imm32           = imm_i;
      end
      OpcLoad: begin
        illegal = (funct3 == 3'b111) ||
                  ((Xlen == 32) && ((funct3 == 3'b011) || (funct3 == 3'b110)));
        dec.reg_wb      = 1'b1;
        dec.alu_use_imm = 1'b1;
        dec.mem_to_reg  = 1'b1;
        dec.mem_type    = MemLoad;
        imm32           = imm_i;
      end
      OpcStore: begin
        illegal         = funct3[2] || ((Xlen == 32) && (funct3 == 3'b011));
        dec.alu_use_imm = 1'b1;
        dec.mem_type    = MemStore;
        imm32           = imm_s;
      end
      OpcBranch: begin
        illegal    = (funct3 == 3'b010) || (funct3 == 3'b011);
        dec.branch = 1'b1;
        dec.aluop  = Branch;
        imm32      = imm_b;
      end
      OpcJal: begin
        dec.reg_wb = 1'b1;
        dec.jump   = Jal;
        imm32      = imm_j;
      end
      OpcJalr: begin
        illegal         = (funct3 != 3'b000);
        dec.reg_wb      = 1'b1;
        dec.alu_use_imm = 1'b1;
        dec.jump        = Jalr;
        imm32           = imm_i;
      end
      OpcLui: begin
        dec.reg_wb      = 1'b1;
        dec.reg_lui     = 1'b1;
        dec.alu_use_imm = 1'b1;
        imm32           = imm_u;
      end
      OpcAuipc: begin
        dec.reg_wb      = 1'b1;
        dec.is_auipc    = 1'b1;
        dec.alu_use_imm = 1'b1;
        imm32           = imm_u;
      end
      OpcMiscMem: ;
      OpcSystem: begin
        if (funct3 != 3'b000) begin
          dec.is_csr = 1'b1;
          dec.reg_wb = 1'b1;
          imm32      = {27'b0, instr_i[19:15]};
        end else if ((instr_i[11:7] != 5'd0) || (instr_i[19:15] != 5'd0)) begin
          illegal = 1'b1;
        end else begin
          case (instr_i[31:20])
            12'h000: dec.is_ecall  = 1'b1;
            12'h001: dec.is_ebreak = 1'b1;
            12'h302: dec.is_mret   = 1'b1;
            default: illegal       = 1'b1;
          endcase
        end
      end
      default: illegal = 1'b1;
    endcase

    if ((instr_i[1:0] != 2'b11) || (instr_i == '0) || (instr_i == '1)) illegal = 1'b1;

    // Illegal instructions still flow, but carry no control side effects.
    if (illegal) dec = '0;
    dec.imm     = illegal ? '0 : Xlen'($signed(imm32));
    dec.illegal = illegal;
    dec.pc      = pc_i;
    dec.rd      = instr_i[11:7];
    dec.rs1     = instr_i[19:15];
    dec.rs2     = instr_i[24:20];
    dec.funct3  = funct3;
    dec.funct7  = instr_i[31:25];
    if (dec.rd == 5'd0) dec.reg_wb = 1'b0;
  end

  bundle_t o_q, o_d, s_q, s_d;
  logic    o_valid_q, o_valid_d, s_valid_q, s_valid_d, in_ready_q;
  logic    in_fire, out_fire;

  assign in_fire  = in_valid_i && in_ready_q;
  assign out_fire = o_valid_q && out_ready_i;

  always_comb begin
    o_d       = o_q;
    s_d       = s_q;
    o_valid_d = o_valid_q;
    s_valid_d = s_valid_q;
    if (flush_i) begin
      o_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (out_fire && s_valid_q) begin
      // in_ready is low while the skid is full, so no input competes here.
      o_d       = s_q;
      o_valid_d = 1'b1;
      s_valid_d = 1'b0;
    end else if (in_fire && (!o_valid_q || out_fire)) begin
      o_d       = dec;
      o_valid_d = 1'b1;
    end else if (in_fire) begin
      s_d       = dec;
      s_valid_d = 1'b1;
    end else if (out_fire) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      o_q        <= '0;
      s_q        <= '0;
      o_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      o_q        <= o_d;
      s_q        <= s_d;
      o_valid_q  <= o_valid_d;
      s_valid_q  <= s_valid_d;
      in_ready_q <= !s_valid_d;
    end
  end

  assign in_ready_o    = in_ready_q;
  assign out_valid_o   = o_valid_q;
  assign pc_o          = o_q.pc;
  assign rd_o          = o_q.rd;
  assign rs1_o         = o_q.rs1;
  assign rs2_o         = o_q.rs2;
  assign funct3_o      = o_q.funct3;
  assign funct7_o      = o_q.funct7;
  assign imm_o         = o_q.imm;
  assign aluop_o       = o_q.aluop;
  assign alu_use_imm_o = o_q.alu_use_imm;
  assign reg_wb_o      = o_q.reg_wb;
  assign reg_lui_o     = o_q.reg_lui;
  assign is_auipc_o    = o_q.is_auipc;
  assign branch_o      = o_q.branch;
  assign mem_to_reg_o  = o_q.mem_to_reg;
  assign is_csr_o      = o_q.is_csr;
  assign jump_o        = o_q.jump;
  assign mem_type_o    = o_q.mem_type;
  assign is_ecall_o    = o_q.is_ecall;
  assign is_ebreak_o   = o_q.is_ebreak;
  assign is_mret_o     = o_q.is_mret;
  assign illegal_o     = o_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboarded bench for decode_stage: an RV64 and an RV32 instance share one stimulus stream,
// each checked against a reference decoder by an independent output monitor.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [63:0] pc;
  always #5 clk = ~clk;

  logic in_ready64, ov64, aui64, wb64, lui64, auipc64, br64, m2r64, csr64, ec64, eb64, mr64, ill64;
  logic [63:0] pc64, imm64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [2:0]  f3_64;
  logic [6:0]  f7_64;
  aluop_e      alu64;
  jump_e       jmp64;
  mem_type_e   mem64;

  logic in_ready32, ov32, aui32, wb32, lui32, auipc32, br32, m2r32, csr32, ec32, eb32, mr32, ill32;
  logic [31:0] pc32, imm32;
  logic [4:0]  rd32, rs1_32, rs2_32;
  logic [2:0]  f3_32;
  logic [6:0]  f7_32;
  aluop_e      alu32;
  jump_e       jmp32;
  mem_type_e   mem32;

  decode_stage #(.Xlen(64)) dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready64),
    .instr_i(instr), .pc_i(pc), .out_valid_o(ov64), .out_ready_i(out_ready), .pc_o(pc64),
    .rd_o(rd64), .rs1_o(rs1_64), .rs2_o(rs2_64), .funct3_o(f3_64), .funct7_o(f7_64),
    .imm_o(imm64), .aluop_o(alu64), .alu_use_imm_o(aui64), .reg_wb_o(wb64),
    .reg_lui_o(lui64), .is_auipc_o(auipc64), .branch_o(br64), .mem_to_reg_o(m2r64),
    .is_csr_o(csr64), .jump_o(jmp64), .mem_type_o(mem64), .is_ecall_o(ec64),
    .is_ebreak_o(eb64), .is_mret_o(mr64), .illegal_o(ill64)
  );

  decode_stage #(.Xlen(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready32),
    .instr_i(instr), .pc_i(pc[31:0]), .out_valid_o(ov32), .out_ready_i(out_ready), .pc_o(pc32),
    .rd_o(rd32), .rs1_o(rs1_32), .rs2_o(rs2_32), .funct3_o(f3_32), .funct7_o(f7_32),
    .imm_o(imm32), .aluop_o(alu32), .alu_use_imm_o(aui32), .reg_wb_o(wb32),
    .reg_lui_o(lui32), .is_auipc_o(auipc32), .branch_o(br32), .mem_to_reg_o(m2r32),
    .is_csr_o(csr32), .jump_o(jmp32), .mem_type_o(mem32), .is_ecall_o(ec32),
    .is_ebreak_o(eb32), .is_mret_o(mr32), .illegal_o(ill32)
  );

  int n_checks = 0, n_pass = 0, n_out64 = 0, n_out32 = 0;
  logic [191:0] q64[$], q32[$];

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Flag order: alu_use_imm, reg_wb, reg_lui, is_auipc, branch, mem_to_reg, is_csr.
  // System order: ecall, ebreak, mret, illegal.
  function automatic logic [191:0] pk(logic [63:0] p, logic [4:0] rd, logic [4:0] rs1,
                                      logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7,
                                      logic [63:0] imm, logic [1:0] alu, logic [6:0] fl,
                                      logic [1:0] jmp, logic [1:0] mem, logic [3:0] sys);
    return {22'd0, p, rd, rs1, rs2, f3, f7, imm, alu, fl, jmp, mem, sys};
  endfunction

  function automatic logic [191:0] view64();
    return pk(pc64, rd64, rs1_64, rs2_64, f3_64, f7_64, imm64, alu64,
              {aui64, wb64, lui64, auipc64, br64, m2r64, csr64}, jmp64, mem64,
              {ec64, eb64, mr64, ill64});
  endfunction

  function automatic logic [191:0] view32();
    return pk({32'd0, pc32}, rd32, rs1_32, rs2_32, f3_32, f7_32, {32'd0, imm32}, alu32,
              {aui32, wb32, lui32, auipc32, br32, m2r32, csr32}, jmp32, mem32,
              {ec32, eb32, mr32, ill32});
  endfunction

  // Reference decoder: immediates via arithmetic shifts of the sign-extended word.
  function automatic logic [191:0] model(logic [31:0] ins, logic [63:0] p, int xlen);
    logic [6:0]  op, f7, fl;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [63:0] imm;
    logic [3:0]  sys;
    longint      si, s12, s20, s25, s31;
    aluop_e      alu;
    jump_e       jmp;
    mem_type_e   mem;
    logic        ok;
    op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; rs1 = ins[19:15]; rs2 = ins[24:20];
    f7 = ins[31:25];
    si = longint'($signed(ins));
    s12 = si >>> 12; s20 = si >>> 20; s25 = si >>> 25; s31 = si >>> 31;
    imm = '0; fl = '0; alu = Add; jmp = JmpNone; mem = MemNone; sys = '0; ok = 1'b1;
    case (op)
      7'b0110011: begin fl = 7'b0100000; alu = Op; end
      7'b0010011: begin fl = 7'b1100000; alu = Op; imm = s20; end
      7'b0111011: begin ok = (xlen == 64); fl = 7'b0100000; alu = Op32; end
      7'b0011011: begin ok = (xlen == 64); fl = 7'b1100000; alu = Op32; imm = s20; end
      7'b0000011: begin
        ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
             ((xlen == 64) && (f3 inside {3'd3, 3'd6}));
        fl = 7'b1100010; mem = MemLoad; imm = s20;
      end
      7'b0100011: begin
        ok = (f3 inside {3'd0, 3'd1, 3'd2}) || ((xlen == 64) && (f3 == 3'd3));
        fl = 7'b1000000; mem = MemStore; imm = (s25 << 5) | 64'(rd);
      end
      7'b1100011: begin
        ok = !(f3 inside {3'd2, 3'd3}); fl = 7'b0000100; alu = Branch;
        imm = (s31 << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
      end
      7'b1101111: begin
        fl = 7'b0100000; jmp = Jal;
        imm = (s31 << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) |
              (64'(ins[30:21]) << 1);
      end
      7'b1100111: begin ok = (f3 == 3'd0); fl = 7'b1100000; jmp = Jalr; imm = s20; end
      7'b0110111: begin fl = 7'b1110000; imm = s12 << 12; end
      7'b0010111: begin fl = 7'b1101000; imm = s12 << 12; end
      7'b0001111: ;
      7'b1110011: begin
        if (f3 != 3'd0) begin
          fl = 7'b0100001; imm = 64'(rs1);
        end else begin
          case (ins)
            32'h00000073: sys = 4'b1000;
            32'h00100073: sys = 4'b0100;
            32'h30200073: sys = 4'b0010;
            default:      ok = 1'b0;
          endcase
        end
      end
      default: ok = 1'b0;
    endcase
    if ((ins == 32'h0) || (ins == 32'hFFFF_FFFF) || (ins[1:0] != 2'b11)) ok = 1'b0;
    if (!ok) begin
      imm = '0; fl = '0; alu = Add; jmp = JmpNone; mem = MemNone; sys = 4'b0001;
    end
    if (rd == 5'd0) fl[5] = 1'b0;
    if (xlen == 32) begin
      imm = {32'd0, imm[31:0]};
      p   = {32'd0, p[31:0]};
    end
    return pk(p, rd, rs1, rs2, f3, f7, imm, alu, fl, jmp, mem, sys);
  endfunction

  // Output monitor: every output fire must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && ov64 && out_ready) begin
      n_out64++;
      if (q64.size() == 0) check("spurious_out64", 192'(ov64), 192'(0));
      else check("bundle64", view64(), q64.pop_front());
    end
    if (!rst && ov32 && out_ready) begin
      n_out32++;
      if (q32.size() == 0) check("spurious_out32", 192'(ov32), 192'(0));
      else check("bundle32", view32(), q32.pop_front());
    end
  end

  // One clock of stimulus; returns whether the RV64 instance accepted the input.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [63:0] p,
                       input logic rdy, input logic fl, output logic acc);
    logic f64, f32;
    in_valid = v; instr = ins; pc = p; flush = fl; out_ready = rdy && !fl;
    @(negedge clk);
    f64 = v && in_ready64;
    f32 = v && in_ready32;
    @(posedge clk);
    if (fl) begin
      q64.delete();
      q32.delete();
    end else begin
      if (f64) q64.push_back(model(ins, p, 64));
      if (f32) q32.push_back(model(ins, p, 32));
    end
    #1;
    acc = f64;
  endtask

  task automatic issue(input logic [31:0] ins);
    logic a;
    cycle(1'b1, ins, {$urandom, $urandom}, 1'b1, 1'b0, a);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, a);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops[13];
    logic [31:0] sysw[3];
    logic [31:0] r;
    int          k;
    ops = '{7'b0110011, 7'b0010011, 7'b0111011, 7'b0011011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111,
            7'b1110011};
    sysw = '{32'h00000073, 32'h00100073, 32'h30200073};
    r = $urandom;
    k = int'($urandom_range(0, 19));
    if (k < 13) r[6:0] = ops[k];
    else if (k == 13) r = sysw[$urandom_range(0, 2)];
    else if (k == 14) begin r[6:0] = 7'b1110011; r[14:12] = 3'd0; end
    else if (k == 15) r = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'hFFFF_FFFF;
    return r;
  endfunction

  initial begin
    logic a, a1, a2, a3;
    int   nacc, base;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; pc = '0; out_ready = 1'b0;
    #12;
    check("reset_handshake", 192'({ov64, in_ready64, ov32, in_ready32}), 192'(4'b0101));
    check("reset_bundle64", view64(), 192'(0));
    check("reset_bundle32", view32(), 192'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back stream.
    base = n_out64; nacc = 0;
    cycle(1'b1, 32'h00500093, 64'h1000, 1'b1, 1'b0, a); nacc += int'(a);
    check("addi_first64", 192'({ov64, imm64, wb64, aui64}), 192'({1'b1, 64'd5, 1'b1, 1'b1}));
    check("addi_first32", 192'({ov32, imm32, wb32, aui32}), 192'({1'b1, 32'd5, 1'b1, 1'b1}));
    cycle(1'b1, 32'h002081B3, 64'h1004, 1'b1, 1'b0, a); nacc += int'(a);
    cycle(1'b1, 32'h0000A203, 64'h1008, 1'b1, 1'b0, a); nacc += int'(a);
    cycle(1'b1, 32'h123452B7, 64'h100C, 1'b1, 1'b0, a); nacc += int'(a);
    idle(1);
    check("b2b_accepts", 192'(nacc), 192'(4));
    check("b2b_outputs", 192'(n_out64 - base), 192'(4));

    // Backpressure fills output and skid registers, then drains in order.
    base = n_out64;
    cycle(1'b1, 32'h00100113, 64'h2000, 1'b0, 1'b0, a1);
    cycle(1'b1, 32'h00200193, 64'h2004, 1'b0, 1'b0, a2);
    check("bp_ready_low", 192'({in_ready64, in_ready32}), 192'(2'b00));
    cycle(1'b1, 32'h00300213, 64'h2008, 1'b0, 1'b0, a3);
    check("bp_accepts", 192'({a1, a2, a3}), 192'(3'b110));
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 32'h00300213, 64'h2008, 1'b1, 1'b0, a);
      if (a) break;
    end
    idle(2);
    check("bp_outputs", 192'(n_out64 - base), 192'(3));
    check("bp_queue_empty", 192'(q64.size()), 192'(0));

    // Flush with both registers full, then with an input firing into the skid.
    base = n_out64;
    cycle(1'b1, 32'h00400293, 64'h3000, 1'b0, 1'b0, a);
    cycle(1'b1, 32'h00500313, 64'h3004, 1'b0, 1'b0, a);
    cycle(1'b1, 32'h00600393, 64'h3008, 1'b0, 1'b1, a);
    check("flush_full", 192'({ov64, in_ready64, ov32, in_ready32}), 192'(4'b0101));
    cycle(1'b1, 32'h00700413, 64'h300C, 1'b0, 1'b0, a);
    cycle(1'b1, 32'h00800493, 64'h3010, 1'b0, 1'b1, a);
    check("flush_fire_in", 192'({a, ov64, in_ready64, ov32, in_ready32}), 192'(5'b10101));
    idle(3);
    check("flush_no_output", 192'(n_out64 - base), 192'(0));

    // Xlen-dependent legality and system classification.
    issue(32'h0010009B);
    check("addiw_rv32", 192'({ill32, wb32}), 192'(2'b10));
    check("addiw_rv64", 192'({ill64, wb64, alu64}), 192'({1'b0, 1'b1, Op32}));
    issue(32'h00000000);
    check("zero_illegal", 192'({ill64, ill32}), 192'(2'b11));
    issue(32'h00000073);
    check("ecall", 192'({ec64, eb64, mr64, ill64}), 192'(4'b1000));
    issue(32'h00100073);
    check("ebreak", 192'({ec64, eb64, mr64, ill64}), 192'(4'b0100));
    issue(32'h30200073);
    check("mret", 192'({ec64, eb64, mr64, ill64}), 192'(4'b0010));
    issue(32'h10500073);
    check("wfi_illegal", 192'({ec64, eb64, mr64, ill64}), 192'(4'b0001));
    issue(32'h30009073);
    check("csrrw_x0", 192'({csr64, wb64, imm64}), 192'({1'b1, 1'b0, 64'd1}));
    idle(1);

    // Randomised traffic with backpressure and occasional flushes.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) != 0), rand_instr(), {$urandom, $urandom},
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0), a);
    end
    idle(4);
    check("rand_drain64", 192'(q64.size()), 192'(0));
    check("rand_drain32", 192'(q32.size()), 192'(0));

    // Asynchronous reset while the skid holds a bundle.
    cycle(1'b1, 32'h00100513, 64'h4000, 1'b0, 1'b0, a);
    cycle(1'b1, 32'h00200593, 64'h4004, 1'b0, 1'b0, a);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_handshake", 192'({ov64, in_ready64, ov32, in_ready32}), 192'(4'b0101));
    check("async_rst_bundle64", view64(), 192'(0));
    check("async_rst_bundle32", view32(), 192'(0));
    q64.delete();
    q32.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    issue(32'h00500093);
    idle(2);
    check("post_reset_drain", 192'({q64.size(), q32.size()}), 192'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
